instruction_decode_queue: RTL and testbench

//  Parametrised RV32I/RV64I decode stage between fetch and execute. Decodes each accepted instruction

---
 rtl/rv_decode_pkg.sv | 42 ++++
 rtl/instruction_field_decoder.sv | 66 ++++++
 rtl/instruction_decode_queue.sv | 102 ++++++++++
 tb/tb_instruction_decode_queue.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_decode_pkg.sv
// Shared RV32I/RV64I decode types: opcodes, instruction format enum, decoded record.
package rv_decode_pkg;

  localparam int unsigned INST_W = 32;
  // Every RV base immediate is a 32-bit value sign-extended to XLEN
  localparam int unsigned IMM_W  = 32;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6
  } inst_format_e;

  typedef struct packed {
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    inst_format_e     format;
    logic [IMM_W-1:0] imm;
    logic             illegal;
  } decoded_inst_t;

endpackage

// File: rtl/instruction_field_decoder.sv
// Combinational RV base-ISA decoder: raw fields, format, 32-bit sign-extended immediate, illegal flag.
module instruction_field_decoder
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INST_W-1:0] inst,
  output decoded_inst_t     dec
);

  // Only RV32 and RV64 datapaths are meaningful
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("instruction_field_decoder: XLEN must be 32 or 64");
  end

  // Field slicing, format selection and immediate assembly
  always_comb begin
    dec         = '0;
    dec.opcode  = inst[6:0];
    dec.funct3  = inst[14:12];
    dec.funct7  = inst[31:25];
    dec.rd      = inst[11:7];
    dec.rs1     = inst[19:15];
    dec.rs2     = inst[24:20];
    dec.format  = FMT_NONE;
    dec.imm     = '0;
    dec.illegal = 1'b0;

    unique case (inst[6:0])
      OPC_LUI, OPC_AUIPC: begin
        dec.format = FMT_U;
        dec.imm    = {inst[31:12], 12'b0};
      end
      OPC_JAL: begin
        dec.format = FMT_J;
        dec.imm    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM: begin
        dec.format = FMT_I;
        dec.imm    = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_STORE: begin
        dec.format = FMT_S;
        dec.imm    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OPC_BRANCH: begin
        dec.format = FMT_B;
        dec.imm    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPC_OP: begin
        dec.format = FMT_R;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase

    // Compressed/reserved encodings are not supported
    if (inst[1:0] != 2'b11) begin
      dec.format  = FMT_NONE;
      dec.imm     = '0;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/instruction_decode_queue.sv
// Decode stage: decodes accepted instructions and buffers them with their PC in a DEPTH-entry FIFO.
module instruction_decode_queue
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [6:0]        inst_opcode,
  output logic [2:0]        inst_funct3,
  output logic [6:0]        inst_funct7,
  output logic [4:0]        inst_rd,
  output logic [4:0]        inst_rs1,
  output logic [4:0]        inst_rs2,
  output logic [2:0]        inst_format,
  output logic [XLEN-1:0]   inst_imm,
  output logic              inst_illegal
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    decoded_inst_t   dec;
  } entry_t;

  entry_t            storage [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  count;
  decoded_inst_t     dec;
  entry_t            head;
  logic              accept;
  logic              pop;

  instruction_field_decoder #(
    .XLEN (XLEN)
  ) u_decoder (
    .inst (inst),
    .dec  (dec)
  );

  // Handshake qualifiers; in_ready deliberately ignores out_ready
  assign in_ready  = reset_n & ~flush & (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Pointer increment with wrap at DEPTH
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // FIFO storage, pointers and occupancy; flush drops everything including a same-cycle pop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (accept) begin
        storage[wptr] <= '{pc: in_pc, dec: dec};
        wptr          <= ptr_inc(wptr);
      end
      if (pop) rptr <= ptr_inc(rptr);
      unique case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head entry drives the outputs directly; no enqueue bypass
  assign head         = storage[rptr];
  assign out_pc       = head.pc;
  assign inst_opcode  = head.dec.opcode;
  assign inst_funct3  = head.dec.funct3;
  assign inst_funct7  = head.dec.funct7;
  assign inst_rd      = head.dec.rd;
  assign inst_rs1     = head.dec.rs1;
  assign inst_rs2     = head.dec.rs2;
  assign inst_format  = head.dec.format;
  assign inst_imm     = XLEN'($signed(head.dec.imm));
  assign inst_illegal = head.dec.illegal;

endmodule

// File: tb/tb_instruction_decode_queue.sv
// Directed bench for instruction_decode_queue: decode vector table plus queue corner sequences.
module tb_instruction_decode_queue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;

  logic              clock;
  logic              reset_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       inst;
  logic [XLEN-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [6:0]        inst_opcode;
  logic [2:0]        inst_funct3;
  logic [6:0]        inst_funct7;
  logic [4:0]        inst_rd;
  logic [4:0]        inst_rs1;
  logic [4:0]        inst_rs2;
  logic [2:0]        inst_format;
  logic [XLEN-1:0]   inst_imm;
  logic              inst_illegal;

  int n_chk  = 0;
  int n_fail = 0;

  instruction_decode_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .inst         (inst),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .inst_opcode  (inst_opcode),
    .inst_funct3  (inst_funct3),
    .inst_funct7  (inst_funct7),
    .inst_rd      (inst_rd),
    .inst_rs1     (inst_rs1),
    .inst_rs2     (inst_rs2),
    .inst_format  (inst_format),
    .inst_imm     (inst_imm),
    .inst_illegal (inst_illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected format codes (NONE=0,R=1,I=2,S=3,B=4,U=5,J=6)
  localparam logic [2:0] F_NONE = 3'd0, F_R = 3'd1, F_I = 3'd2, F_S = 3'd3,
                         F_B = 3'd4, F_U = 3'd5, F_J = 3'd6;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        illegal;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    vecs[0] = '{"addi",  32'hFFF10093, 32'h100, 7'h13, 3'd0, 7'h7F, 5'd1,  5'd2, 5'd31, F_I,    32'hFFFFFFFF, 1'b0};
    vecs[1] = '{"sw",    32'h00532423, 32'h104, 7'h23, 3'd2, 7'h00, 5'd8,  5'd6, 5'd5,  F_S,    32'h00000008, 1'b0};
    vecs[2] = '{"beq",   32'hFE000EE3, 32'h108, 7'h63, 3'd0, 7'h7F, 5'd29, 5'd0, 5'd0,  F_B,    32'hFFFFFFFC, 1'b0};
    vecs[3] = '{"lui",   32'h123450B7, 32'h10C, 7'h37, 3'd5, 7'h09, 5'd1,  5'd8, 5'd3,  F_U,    32'h12345000, 1'b0};
    vecs[4] = '{"jal",   32'h008000EF, 32'h110, 7'h6F, 3'd0, 7'h00, 5'd1,  5'd0, 5'd8,  F_J,    32'h00000008, 1'b0};
    vecs[5] = '{"add",   32'h002081B3, 32'h114, 7'h33, 3'd0, 7'h00, 5'd3,  5'd1, 5'd2,  F_R,    32'h00000000, 1'b0};
    vecs[6] = '{"zero",  32'h00000000, 32'h118, 7'h00, 3'd0, 7'h00, 5'd0,  5'd0, 5'd0,  F_NONE, 32'h00000000, 1'b1};
    vecs[7] = '{"op7f",  32'h0000007F, 32'h11C, 7'h7F, 3'd0, 7'h00, 5'd0,  5'd0, 5'd0,  F_NONE, 32'h00000000, 1'b1};

    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    inst      = 32'h0;
    in_pc     = '0;

    // Reset state
    #12;
    chk("rst_in_ready",  64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc",    64'(out_pc), 64'd0);
    chk("rst_format",    64'(inst_format), 64'd0);
    #5 reset_n = 1'b1;
    step();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Decode table: single entry in, visible next cycle, popped on the following edge
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      inst     = vecs[i].inst;
      in_pc    = vecs[i].pc;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      inst     = 32'h0;
      chk({vecs[i].name, "_valid"},   64'(out_valid),    64'd1);
      chk({vecs[i].name, "_pc"},      64'(out_pc),       64'(vecs[i].pc));
      chk({vecs[i].name, "_opcode"},  64'(inst_opcode),  64'(vecs[i].opcode));
      chk({vecs[i].name, "_funct3"},  64'(inst_funct3),  64'(vecs[i].funct3));
      chk({vecs[i].name, "_funct7"},  64'(inst_funct7),  64'(vecs[i].funct7));
      chk({vecs[i].name, "_rd"},      64'(inst_rd),      64'(vecs[i].rd));
      chk({vecs[i].name, "_rs1"},     64'(inst_rs1),     64'(vecs[i].rs1));
      chk({vecs[i].name, "_rs2"},     64'(inst_rs2),     64'(vecs[i].rs2));
      chk({vecs[i].name, "_format"},  64'(inst_format),  64'(vecs[i].fmt));
      chk({vecs[i].name, "_imm"},     64'(inst_imm),     64'(vecs[i].imm));
      chk({vecs[i].name, "_illegal"}, 64'(inst_illegal), 64'(vecs[i].illegal));
      step();
      chk({vecs[i].name, "_drained"}, 64'(out_valid), 64'd0);
    end

    // Backpressure: fill with out_ready=0, then drain in order
    out_ready = 1'b0;
    in_valid  = 1'b1;
    inst      = vecs[0].inst; in_pc = 32'h200;
    step();
    inst      = vecs[1].inst; in_pc = 32'h204;
    step();
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_head_pc",  64'(out_pc), 64'h200);
    inst      = vecs[3].inst; in_pc = 32'h208;
    step();
    chk("full_hold_pc",  64'(out_pc), 64'h200);
    out_ready = 1'b1;
    #1;
    chk("full_pop_no_accept", 64'(in_ready), 64'd0);
    step();
    chk("drain1_pc",       64'(out_pc), 64'h204);
    chk("drain1_format",   64'(inst_format), 64'(F_S));
    chk("drain1_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("drain2_pc",     64'(out_pc), 64'h208);
    chk("drain2_imm",    64'(inst_imm), 64'h12345000);
    chk("drain2_valid",  64'(out_valid), 64'd1);
    step();
    chk("drain_empty", 64'(out_valid), 64'd0);

    // Flush with a full queue, concurrent in_valid and out_ready
    out_ready = 1'b0;
    in_valid  = 1'b1;
    inst      = vecs[5].inst; in_pc = 32'h280;
    step();
    in_pc     = 32'h284;
    step();
    flush     = 1'b1;
    out_ready = 1'b1;
    in_pc     = 32'h288;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    step();
    flush = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    in_pc = 32'h300;
    inst  = vecs[1].inst;
    #1;
    chk("post_flush_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("post_flush_valid", 64'(out_valid), 64'd1);
    chk("post_flush_pc",    64'(out_pc), 64'h300);
    step();
    chk("post_flush_drained", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    inst      = vecs[0].inst; in_pc = 32'h380;
    step();
    in_pc     = 32'h384;
    step();
    in_valid  = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready",  64'(in_ready), 64'd0);
    chk("arst_out_pc",    64'(out_pc), 64'd0);
    chk("arst_imm",       64'(inst_imm), 64'd0);
    chk("arst_rd",        64'(inst_rd), 64'd0);
    step();
    #2 reset_n = 1'b1;
    step();
    chk("rearm_in_ready", 64'(in_ready), 64'd1);
    chk("rearm_empty",    64'(out_valid), 64'd0);
    in_valid = 1'b1;
    inst     = vecs[2].inst; in_pc = 32'h400;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rearm_valid",  64'(out_valid), 64'd1);
    chk("rearm_pc",     64'(out_pc), 64'h400);
    chk("rearm_format", 64'(inst_format), 64'(F_B));
    step();
    chk("rearm_drained", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
